adder_sweep_checker: RTL

Self-checking stimulus sequencer that sits directly upstream and downstream of the two-bit dataflow adder. It drives every {Cin, A, B} operand combination into the adder, holding each for a programmable number of cycles. On the last cycle of each vector it samples the adder's Sum and Carry and compares them against an internal reference. It then reports the error count, the index of the first failing vector, and an overall pass/fail flag.

---
 rtl/adder_sweep_checker_if.sv | 31 +++
 rtl/adder_sweep_checker.sv | 114 +++++++++++
 2 files changed

// File: rtl/adder_sweep_checker_if.sv
// Connects the sweep checker to the adder under check and to its controlling agent.
// The master side (checker) drives the operands and status. The slave side supplies start and the adder result.
interface adder_sweep_checker_if #(
  parameter int WIDTH = 2
);
  logic                 start;
  logic [WIDTH-1:0]     a_out;
  logic [WIDTH-1:0]     b_out;
  logic                 cin_out;
  logic [WIDTH-1:0]     sum_in;
  logic                 carry_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 err_pulse;
  logic [2*WIDTH+1:0]   err_count;
  logic [2*WIDTH:0]     first_err_idx;
  logic [2*WIDTH:0]     vec_idx;

  modport master (
    input  start, sum_in, carry_in,
    output a_out, b_out, cin_out, busy, done, pass, err_pulse,
           err_count, first_err_idx, vec_idx
  );

  modport slave (
    output start, sum_in, carry_in,
    input  a_out, b_out, cin_out, busy, done, pass, err_pulse,
           err_count, first_err_idx, vec_idx
  );
endinterface

// File: rtl/adder_sweep_checker.sv
// Exhaustive sweep of {cin, a, b} into a WIDTH-bit adder. Each vector is held DWELL cycles and checked on the last one.
// Reports the mismatch count, the first failing vector and a pass flag.
module adder_sweep_checker #(
  parameter int WIDTH = 2,
  parameter int DWELL = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adder_sweep_checker_if.master  bus
);
  localparam int IW  = 2 * WIDTH + 1;
  localparam int CW  = 2 * WIDTH + 2;
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [IW-1:0]  LAST_VEC   = '1;
  localparam logic [DCW-1:0] LAST_DWELL = DCW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [DCW-1:0]  dwell_q;
  logic [IW-1:0]   vec_idx_q;
  logic [IW-1:0]   first_err_idx_q;
  logic [CW-1:0]   err_count_q;
  logic [CW-1:0]   err_count_d;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            err_pulse_q;

  logic [WIDTH:0]  exp_result;
  logic            mismatch;
  logic            sample_now;

  // The operands are wired straight from the vector index: b is the innermost field and cin the outermost.
  assign bus.b_out         = vec_idx_q[WIDTH-1:0];
  assign bus.a_out         = vec_idx_q[2*WIDTH-1:WIDTH];
  assign bus.cin_out       = vec_idx_q[2*WIDTH];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_pulse     = err_pulse_q;
  assign bus.err_count     = err_count_q;
  assign bus.first_err_idx = first_err_idx_q;
  assign bus.vec_idx       = vec_idx_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    exp_result  = {1'b0, bus.a_out} + {1'b0, bus.b_out} + {{WIDTH{1'b0}}, bus.cin_out};
    mismatch    = ({bus.carry_in, bus.sum_in} != exp_result);
    sample_now  = (state_q == RUN) && (dwell_q == LAST_DWELL);
    err_count_d = err_count_q;
    if (sample_now && mismatch && (err_count_q != '1)) begin
      err_count_d = err_count_q + CW'(1);
    end
  end

  // NOTE: all sequential state uses non-blocking assignments. Every register then updates from pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      dwell_q         <= '0;
      vec_idx_q       <= '0;
      first_err_idx_q <= '0;
      err_count_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_pulse_q     <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q         <= RUN;
            dwell_q         <= '0;
            vec_idx_q       <= '0;
            first_err_idx_q <= '0;
            err_count_q     <= '0;
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
          end
        end
        RUN: begin
          if (sample_now) begin
            err_pulse_q <= mismatch;
            err_count_q <= err_count_d;
            if (mismatch && (err_count_q == '0)) begin
              first_err_idx_q <= vec_idx_q;
            end
            if (vec_idx_q == LAST_VEC) begin
              // The operands keep the last vector in DONE because vec_idx_q is left unchanged.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == '0);
            end else begin
              vec_idx_q <= vec_idx_q + IW'(1);
              dwell_q   <= '0;
            end
          end else begin
            dwell_q <= dwell_q + DCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
